// File: rtl/bd_word_serializer.sv
// Wide-to-narrow ready/valid serializer on the BD transmit link.
// Each accepted word leaves as IN_BITS/OUT_BITS chunks; out_last flags the final chunk.
module bd_word_serializer #(
    parameter int IN_BITS   = 32,
    parameter int OUT_BITS  = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_BITS-1:0]  in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [OUT_BITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy
);

    localparam int NCHUNK = IN_BITS / OUT_BITS;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    generate
        if (IN_BITS % OUT_BITS != 0) begin : g_bad_width
            $error("bd_word_serializer: IN_BITS must be a multiple of OUT_BITS");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IN_BITS-1:0]  shreg_q, shreg_d;
    logic                last_q, last_d;
    logic [OUT_BITS-1:0] head;
    logic [IN_BITS-1:0]  shifted;
    logic                load;

    // Output end of the shift register is the MSB slice or the LSB slice.
    generate
        if (MSB_FIRST) begin : g_msb
            assign head    = shreg_q[IN_BITS-1 -: OUT_BITS];
            assign shifted = shreg_q << OUT_BITS;
        end else begin : g_lsb
            assign head    = shreg_q[OUT_BITS-1:0];
            assign shifted = shreg_q >> OUT_BITS;
        end
    endgenerate

    // Ready in the last-chunk cycle lets the next word follow with no bubble.
    assign in_ready  = !reset && ((state_q == IDLE) ||
                                  ((state_q == SEND) && out_ready && last_q));
    assign load      = in_valid && in_ready;
    assign out_data  = head;
    assign out_valid = (state_q == SEND);
    assign out_last  = last_q;
    assign busy      = (state_q == SEND);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        last_d  = last_q;
        if (load) begin
            state_d = SEND;
            shreg_d = in_data;
            cnt_d   = '0;
            last_d  = (LAST_CNT == '0);
        end else if ((state_q == SEND) && out_ready) begin
            if (!last_q) begin
                shreg_d = shifted;
                cnt_d   = cnt_q + 1'b1;
                last_d  = (cnt_d == LAST_CNT);
            end else begin
                // Clearing the register keeps out_data at zero while idle.
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
                last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            last_q  <= last_d;
        end
    end

endmodule
